// File: rtl/board_renderer.sv
// Renders a GRID_W x GRID_H board as CELL_PX x CELL_PX tiles (border, cursor, 7x7 glyph) into a pixel stream.
// Latency: first pixel valid 3 cycles after start; one cell tested per SEEK cycle.
// Backpressure: valid/ready; x_out/y_out/colour hold while plot_valid && !plot_ready.
module board_renderer #(
    parameter int GRID_W     = 3,
    parameter int GRID_H     = 3,
    parameter int STATE_SIZE = 4,
    parameter int CELL_PX    = 9,
    parameter int ORIGIN_X   = 0,
    parameter int ORIGIN_Y   = 0
) (
    input  logic                                 clock,
    input  logic                                 resetn,
    input  logic                                 start,
    input  logic                                 partial,
    input  logic [GRID_W*GRID_H-1:0]             dirty,
    input  logic [GRID_W*GRID_H-1:0]             cursorGrid,
    input  logic [GRID_W*GRID_H-1:0]             revealGrid,
    input  logic [STATE_SIZE*GRID_W*GRID_H-1:0]  states,
    output logic [7:0]                           x_out,
    output logic [6:0]                           y_out,
    output logic [2:0]                           colour,
    output logic                                 plot_valid,
    input  logic                                 plot_ready,
    output logic                                 busy,
    output logic                                 done
);
    localparam int N  = GRID_W * GRID_H;
    localparam int KW = $clog2(N + 1);
    localparam int PW = $clog2(CELL_PX);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SEEK  = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_PIXEL = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]            state;
    logic [N-1:0]          mask;
    logic [KW-1:0]         k;
    logic [3:0]            cx, cy, next_cx, next_cy;
    logic                  cur_r, rev_r;
    logic [STATE_SIZE-1:0] code_r;
    logic [PW-1:0]         px, py;
    logic                  last_issued;
    logic [2:0]            pix_colour;
    logic [48:0]           glyph_bits;
    logic                  glyph;
    int                    ix, iy;

    // Rows top to bottom, leftmost pixel in the row MSB; bit (iy,ix) lands at 48-(iy*7+ix).
    function automatic logic [48:0] font_bits(input logic [STATE_SIZE-1:0] code);
        case (32'(code))
            0: font_bits = {7'b0011100, 7'b0100010, 7'b0100110, 7'b0101010, 7'b0110010, 7'b0100010, 7'b0011100};
            1: font_bits = {7'b0001000, 7'b0011000, 7'b0001000, 7'b0001000, 7'b0001000, 7'b0001000, 7'b0011100};
            2: font_bits = {7'b0011100, 7'b0100010, 7'b0000010, 7'b0000100, 7'b0001000, 7'b0010000, 7'b0111110};
            3: font_bits = {7'b0011100, 7'b0100010, 7'b0000010, 7'b0001100, 7'b0000010, 7'b0100010, 7'b0011100};
            4: font_bits = {7'b0000100, 7'b0001100, 7'b0010100, 7'b0100100, 7'b0111110, 7'b0000100, 7'b0000100};
            5: font_bits = {7'b0111110, 7'b0100000, 7'b0111100, 7'b0000010, 7'b0000010, 7'b0100010, 7'b0011100};
            6: font_bits = {7'b0011100, 7'b0100000, 7'b0100000, 7'b0111100, 7'b0100010, 7'b0100010, 7'b0011100};
            7: font_bits = {7'b0111110, 7'b0000010, 7'b0000100, 7'b0001000, 7'b0010000, 7'b0010000, 7'b0010000};
            8: font_bits = {7'b0011100, 7'b0100010, 7'b0100010, 7'b0011100, 7'b0100010, 7'b0100010, 7'b0011100};
            9: font_bits = {7'b0001000, 7'b0101010, 7'b0011100, 7'b1111111, 7'b0011100, 7'b0101010, 7'b0001000};
            default: font_bits = '0;
        endcase
    endfunction

    always_comb begin
        next_cx = cx + 4'd1;
        next_cy = cy;
        if (cx == 4'(GRID_W - 1)) begin
            next_cx = '0;
            next_cy = cy + 4'd1;
        end
    end

    always_comb begin
        ix         = int'(px) - 1;
        iy         = int'(py) - 1;
        glyph_bits = font_bits(code_r);
        glyph      = 1'b0;
        pix_colour = 3'b000;
        if (px == '0 || py == '0 || px == PW'(CELL_PX - 1) || py == PW'(CELL_PX - 1)) begin
            pix_colour = cur_r ? 3'b100 : 3'b111;
        end else begin
            if (ix < 7 && iy < 7)
                glyph = |(glyph_bits & (49'd1 << (48 - (iy * 7 + ix))));
            if (rev_r && glyph) begin
                if (32'(code_r) <= 32'd8)
                    pix_colour = 3'b111;
                else if (32'(code_r) == 32'd9)
                    pix_colour = 3'b100;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state       <= S_IDLE;
            mask        <= '0;
            k           <= '0;
            cx          <= '0;
            cy          <= '0;
            cur_r       <= 1'b0;
            rev_r       <= 1'b0;
            code_r      <= '0;
            px          <= '0;
            py          <= '0;
            last_issued <= 1'b0;
            x_out       <= '0;
            y_out       <= '0;
            colour      <= '0;
            plot_valid  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mask  <= partial ? dirty : '1;
                        k     <= '0;
                        cx    <= '0;
                        cy    <= '0;
                        busy  <= 1'b1;
                        state <= S_SEEK;
                    end
                end
                S_SEEK: begin
                    if (k == KW'(N)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (mask[k]) begin
                        state <= S_LOAD;
                    end else begin
                        k  <= k + 1'b1;
                        cx <= next_cx;
                        cy <= next_cy;
                    end
                end
                S_LOAD: begin
                    cur_r       <= cursorGrid[k];
                    rev_r       <= revealGrid[k];
                    code_r      <= states[k*STATE_SIZE +: STATE_SIZE];
                    px          <= '0;
                    py          <= '0;
                    last_issued <= 1'b0;
                    state       <= S_PIXEL;
                end
                S_PIXEL: begin
                    // Output register refills only when empty or draining, so stalled pixels stay put.
                    if (!plot_valid || plot_ready) begin
                        if (!last_issued) begin
                            x_out      <= 8'(ORIGIN_X + int'(cx) * CELL_PX + int'(px));
                            y_out      <= 7'(ORIGIN_Y + int'(cy) * CELL_PX + int'(py));
                            colour     <= pix_colour;
                            plot_valid <= 1'b1;
                            if (px == PW'(CELL_PX - 1)) begin
                                px <= '0;
                                if (py == PW'(CELL_PX - 1))
                                    last_issued <= 1'b1;
                                else
                                    py <= py + 1'b1;
                            end else begin
                                px <= px + 1'b1;
                            end
                        end else begin
                            plot_valid <= 1'b0;
                            k          <= k + 1'b1;
                            cx         <= next_cx;
                            cy         <= next_cy;
                            state      <= S_SEEK;
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_board_renderer.sv
// Bench for board_renderer: vector table for cell colours, reference pixel model, throttling, reset and restart cases.
module tb_board_renderer;
    localparam int GW = 3, GH = 3, SS = 4, P = 9, OX = 0, OY = 0;
    localparam int N = GW * GH;
    localparam int FULL = N * P * P;

    logic clock = 1'b0, resetn = 1'b0, start = 1'b0, partial = 1'b0, plot_ready = 1'b0;
    logic [N-1:0] dirty = '0, cursorGrid = '0, revealGrid = '0;
    logic [SS*N-1:0] states = '0;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour;
    logic plot_valid, busy, done;

    board_renderer #(.GRID_W(GW), .GRID_H(GH), .STATE_SIZE(SS), .CELL_PX(P),
                     .ORIGIN_X(OX), .ORIGIN_Y(OY)) dut (
        .clock(clock), .resetn(resetn), .start(start), .partial(partial), .dirty(dirty),
        .cursorGrid(cursorGrid), .revealGrid(revealGrid), .states(states),
        .x_out(x_out), .y_out(y_out), .colour(colour), .plot_valid(plot_valid),
        .plot_ready(plot_ready), .busy(busy), .done(done));

    always #5 clock = ~clock;

    typedef struct { int x; int y; int c; } pix_t;
    typedef struct { bit cur; bit rev; int code; int px; int py; int exp_c; } vec_t;

    pix_t  exp_q[$];
    string font [10];
    int total = 0, bad = 0;
    int cyc = 0, cap_n = 0, done_cnt = 0, start_cyc = 0;
    int first_valid = -1, last_xfer = -1, done_at = -1;
    int cap_x [FULL], cap_y [FULL], cap_c [FULL];
    int ready_pct = 100;
    logic stall_prev = 1'b0;
    logic [18:0] stall_dat = '0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_colour(input int cur, input int rev, input int code, input int px, input int py);
        int ix, iy;
        bit g;
        if (px == 0 || py == 0 || px == P - 1 || py == P - 1) return cur ? 4 : 7;
        if (rev == 0) return 0;
        ix = px - 1;
        iy = py - 1;
        g = 0;
        if (ix < 7 && iy < 7 && code < 10) g = (font[code][iy*7+ix] == "#");
        if (g && code <= 8) return 7;
        if (g && code == 9) return 4;
        return 0;
    endfunction

    task automatic build_expected(input logic [N-1:0] m);
        pix_t p;
        exp_q.delete();
        for (int kk = 0; kk < N; kk++) begin
            if (m[kk]) begin
                for (int py = 0; py < P; py++) begin
                    for (int px = 0; px < P; px++) begin
                        p.x = (OX + (kk % GW) * P + px) % 256;
                        p.y = (OY + (kk / GW) * P + py) % 128;
                        p.c = ref_colour(int'(cursorGrid[kk]), int'(revealGrid[kk]),
                                         int'(states[kk*SS +: SS]), px, py);
                        exp_q.push_back(p);
                    end
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial forever begin
        @(posedge clock);
        #1;
        plot_ready = ($urandom_range(99) < ready_pct);
    end

    always @(negedge clock) begin
        pix_t p;
        if (resetn) begin
            if (stall_prev)
                check("stall_hold", int'({x_out, y_out, colour, plot_valid}), int'(stall_dat));
            if (plot_valid && first_valid < 0) first_valid = cyc - start_cyc;
            if (plot_valid && plot_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_pixel", 1, 0);
                end else begin
                    p = exp_q.pop_front();
                    total++;
                    if (int'(x_out) != p.x || int'(y_out) != p.y || int'(colour) != p.c) begin
                        bad++;
                        $display("FAIL pixel %0d: got (%0d,%0d,c=%0d) expected (%0d,%0d,c=%0d)",
                                 cap_n, x_out, y_out, colour, p.x, p.y, p.c);
                    end
                end
                if (cap_n < FULL) begin
                    cap_x[cap_n] = int'(x_out);
                    cap_y[cap_n] = int'(y_out);
                    cap_c[cap_n] = int'(colour);
                end
                cap_n++;
                last_xfer = cyc + 1;
            end
            if (done) begin
                done_cnt++;
                done_at = cyc - start_cyc;
            end
            stall_prev = plot_valid && !plot_ready;
            stall_dat  = {x_out, y_out, colour, plot_valid};
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic kick(input bit part, input logic [N-1:0] dm);
        cap_n = 0; done_cnt = 0; first_valid = -1; last_xfer = -1; done_at = -1;
        @(posedge clock); #1;
        start = 1'b1; partial = part; dirty = dm;
        @(posedge clock); #1;
        start = 1'b0;
        start_cyc = cyc;
        check("busy_rise", int'(busy), 1);
    endtask

    task automatic render(input bit part, input logic [N-1:0] dm, input bit mid_start);
        build_expected(part ? dm : '1);
        kick(part, dm);
        for (int w = 0; w < 6000 && done_cnt == 0; w++) begin
            @(posedge clock); #1;
            start = (mid_start && w == 200);
        end
        start = 1'b0;
        if (done_cnt == 0) check("render_timeout", 0, 1);
        repeat (3) @(posedge clock);
        #1;
        check("done_pulses", done_cnt, 1);
        check("busy_after", int'(busy), 0);
        check("pixels_left", exp_q.size(), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_x"}, int'(x_out), 0);
        check({tag, "_y"}, int'(y_out), 0);
        check({tag, "_colour"}, int'(colour), 0);
        check({tag, "_valid"}, int'(plot_valid), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    task automatic randomize_grid();
        cursorGrid = N'($urandom);
        revealGrid = N'($urandom);
        for (int kk = 0; kk < N; kk++) states[kk*SS +: SS] = SS'($urandom_range(0, 15));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tv [12];
        logic [N-1:0] dm;

        font[0] = {"..###..", ".#...#.", ".#..##.", ".#.#.#.", ".##..#.", ".#...#.", "..###.."};
        font[1] = {"...#...", "..##...", "...#...", "...#...", "...#...", "...#...", "..###.."};
        font[2] = {"..###..", ".#...#.", ".....#.", "....#..", "...#...", "..#....", ".#####."};
        font[3] = {"..###..", ".#...#.", ".....#.", "...##..", ".....#.", ".#...#.", "..###.."};
        font[4] = {"....#..", "...##..", "..#.#..", ".#..#..", ".#####.", "....#..", "....#.."};
        font[5] = {".#####.", ".#.....", ".####..", ".....#.", ".....#.", ".#...#.", "..###.."};
        font[6] = {"..###..", ".#.....", ".#.....", ".####..", ".#...#.", ".#...#.", "..###.."};
        font[7] = {".#####.", ".....#.", "....#..", "...#...", "..#....", "..#....", "..#...."};
        font[8] = {"..###..", ".#...#.", ".#...#.", "..###..", ".#...#.", ".#...#.", "..###.."};
        font[9] = {"...#...", ".#.#.#.", "..###..", "#######", "..###..", ".#.#.#.", "...#..."};

        //          cur rev code px py colour
        tv[0]  = '{1'b0, 1'b0, 0,  0, 0, 7};
        tv[1]  = '{1'b1, 1'b0, 0,  0, 0, 4};
        tv[2]  = '{1'b1, 1'b0, 0,  8, 4, 4};
        tv[3]  = '{1'b0, 1'b0, 1,  4, 1, 0};
        tv[4]  = '{1'b0, 1'b1, 1,  4, 1, 7};
        tv[5]  = '{1'b0, 1'b1, 1,  1, 1, 0};
        tv[6]  = '{1'b0, 1'b1, 9,  4, 4, 4};
        tv[7]  = '{1'b0, 1'b1, 9,  1, 4, 4};
        tv[8]  = '{1'b0, 1'b1, 9,  1, 1, 0};
        tv[9]  = '{1'b0, 1'b1, 12, 4, 4, 0};
        tv[10] = '{1'b0, 1'b1, 8,  2, 2, 7};
        tv[11] = '{1'b1, 1'b1, 0,  3, 3, 0};

        // Reset state, and a start coinciding with reset is dropped.
        repeat (3) @(posedge clock);
        #1;
        check_outputs_zero("reset");
        start = 1'b1;
        @(posedge clock); #1;
        resetn = 1'b1;
        start = 1'b0;
        @(posedge clock); #1;
        check("start_in_reset_busy", int'(busy), 0);
        check("start_in_reset_valid", int'(plot_valid), 0);

        // Full render at full rate.
        cursorGrid = '0;
        revealGrid = '1;
        for (int kk = 0; kk < N; kk++) states[kk*SS +: SS] = SS'($urandom_range(0, 15));
        ready_pct = 100;
        render(1'b0, '0, 1'b0);
        check("full_count", cap_n, FULL);
        check("first_x", cap_x[0], 0);
        check("first_y", cap_y[0], 0);
        check("first_colour", cap_c[0], 7);
        check("last_x", cap_x[FULL-1], 26);
        check("last_y", cap_y[FULL-1], 26);
        check("first_valid_latency", first_valid, 3);
        check("done_after_last", done_at, last_xfer + 1 - start_cyc);

        // Single-cell colour vectors on cell 4.
        for (int i = 0; i < 12; i++) begin
            randomize_grid();
            cursorGrid[4] = tv[i].cur;
            revealGrid[4] = tv[i].rev;
            states[4*SS +: SS] = SS'(tv[i].code);
            ready_pct = (i % 2 == 0) ? 100 : 60;
            render(1'b1, N'(9'b000010000), 1'b0);
            check("vec_count", cap_n, 81);
            check($sformatf("vec%0d_colour", i), cap_c[tv[i].py*P + tv[i].px], tv[i].exp_c);
            if (i == 0) begin
                check("cell4_first_x", cap_x[0], 9);
                check("cell4_first_y", cap_y[0], 9);
                check("cell4_last_x", cap_x[80], 17);
                check("cell4_last_y", cap_y[80], 17);
            end
            if (tv[i].cur) begin
                for (int px = 0; px < P; px++) begin
                    check("cursor_top", cap_c[px], 4);
                    check("cursor_bottom", cap_c[8*P + px], 4);
                end
            end
        end

        // Empty partial mask: no pixels, done after one SEEK per cell plus one.
        render(1'b1, '0, 1'b0);
        check("empty_count", cap_n, 0);
        check("empty_done_latency", done_at, N + 1);
        check("empty_no_valid", first_valid, -1);

        // Throttled renders with random boards.
        ready_pct = 50;
        randomize_grid();
        render(1'b0, '0, 1'b0);
        check("throttled_count", cap_n, FULL);
        randomize_grid();
        dm = N'($urandom);
        ready_pct = 35;
        render(1'b1, dm, 1'b0);
        check("throttled_partial_count", cap_n, $countones(dm) * 81);

        // Reset after 100 accepted pixels aborts silently.
        ready_pct = 100;
        randomize_grid();
        build_expected('1);
        kick(1'b0, '0);
        for (int w = 0; w < 2000 && cap_n < 100; w++) begin
            @(posedge clock); #1;
        end
        check("reached_100", int'(cap_n >= 100), 1);
        resetn = 1'b0;
        @(posedge clock); #1;
        check_outputs_zero("midreset");
        resetn = 1'b1;
        exp_q.delete();
        done_cnt = 0;
        repeat (20) @(posedge clock);
        #1;
        check("midreset_no_done", done_cnt, 0);
        check("midreset_idle_valid", int'(plot_valid), 0);
        ready_pct = 70;
        render(1'b0, '0, 1'b0);
        check("after_reset_count", cap_n, FULL);

        // Start pulsed mid-render is ignored.
        ready_pct = 100;
        randomize_grid();
        render(1'b0, '0, 1'b1);
        check("mid_start_count", cap_n, FULL);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
